ab_pipe_flex: RTL and testbench
===============================

AB_PIPE_FLEX -- requirements
Module: ab_pipe_flex

Interface
REQ-001 SHALL have parameter W, default 8: operand and result width in bits, W >= 1.
REQ-002 SHALL have parameter DEPTH, default 2: number of register stages, DEPTH >= 1.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port op, input, 2: function select, 00 AND, 01 OR, 10 XOR, 11 NAND.
REQ-006 SHALL have ports a and b, input, W each: operands.
REQ-007 SHALL have port in_valid, input, 1: upstream offers a, b, op this cycle.
REQ-008 SHALL have port in_ready, output, 1: block accepts the offered operands this cycle.
REQ-009 SHALL have port out_valid, output, 1: q holds a valid result.
REQ-010 SHALL have port out_ready, input, 1: downstream takes q this cycle.
REQ-011 SHALL have port q, output, W: result from the last stage.
REQ-012 SHALL have port flush, input, 1: synchronous discard of all in-flight results.
REQ-013 SHALL have port occupancy, output, $clog2(DEPTH+1): number of valid stages.

Function
REQ-014 SHALL compute f = op(a, b) bitwise at the accepting edge; op is sampled with its operands, so later op changes do not affect results in flight.
REQ-015 SHALL hold per stage k (0..DEPTH-1) a data register d[k] (W bits) and a valid bit v[k]; q = d[DEPTH-1]; out_valid = v[DEPTH-1].
REQ-016 SHALL define advance flags: adv[DEPTH-1] = !v[DEPTH-1] | out_ready; adv[k] = !v[k] | adv[k+1] for k < DEPTH-1.
REQ-017 SHALL drive in_ready = adv[0] & !flush, combinationally.
REQ-018 SHALL, on an edge where adv[0] is 1, load d[0] <= f and v[0] <= in_valid & in_ready.
REQ-019 SHALL, on an edge where adv[k] is 1 (k >= 1), load d[k] <= d[k-1] and v[k] <= v[k-1].
REQ-020 SHALL hold d[k] and v[k] unchanged on an edge where adv[k] is 0.
REQ-021 SHALL give DEPTH-cycle latency with no stall: operands accepted at edge t appear with out_valid = 1 after edge t+DEPTH-1.
REQ-022 SHALL sustain one accept per cycle while out_ready = 1.
REQ-023 SHALL collapse bubbles: an empty stage accepts from upstream even while downstream stages stall.
REQ-024 SHALL never drop, duplicate or reorder results; q and out_valid remain stable while out_valid = 1 and out_ready = 0.
REQ-025 SHALL, on an edge with flush = 1, clear all v[k] to 0, accept nothing, and leave d[k] unchanged; flush takes priority over every advance.
REQ-026 SHALL drive occupancy = count of set v[k], registered-state derived, range 0..DEPTH.
REQ-027 SHALL treat a transfer at the output as out_valid & out_ready on the same edge; a result entering the last stage on that edge is not itself consumed.

Reset
REQ-028 SHALL, while reset = 1, force all v[k] = 0 and d[k] = 0 immediately: out_valid = 0, q = 0, occupancy = 0, in_ready = !flush.
REQ-029 SHALL discard all in-flight results on reset assertion mid-operation; the first accept after release occurs on the first rising edge with reset = 0.

Verification
REQ-030 SHALL pass: W=8, DEPTH=2, op=00, a=0xF0, b=0x3C, in_valid one cycle, out_ready=1 -> out_valid after second edge, q=0x30, occupancy 1 then 0.
REQ-031 SHALL pass: op cycles 00,01,10,11 on consecutive cycles with a=0xAA, b=0x0F -> q sequence 0x0A, 0xAF, 0xA5, 0xF5 on consecutive cycles, no gaps.
REQ-032 SHALL pass: DEPTH=3, out_ready=0 with continuous in_valid -> exactly 3 accepts, in_ready drops to 0, occupancy=3, q stable; raise out_ready -> results drain in order.
REQ-033 SHALL pass: single item in last stage stalled, new accept -> it advances into empty stages behind it (bubble collapse), occupancy 2.
REQ-034 SHALL pass: flush with occupancy=2 and in_valid=1 -> in_ready=0 that cycle, occupancy=0 and out_valid=0 after the edge, offered item not accepted.
REQ-035 SHALL pass: reset asserted asynchronously mid-stream between edges -> out_valid=0, q=0, occupancy=0 immediately; normal accepts resume after release.

Source files
------------

// File: rtl/ab_pipe_flex.sv
// Elastic DEPTH-stage pipeline computing a bitwise AND/OR/XOR/NAND of two operands.
// Valid/ready handshake on both sides, bubble collapse, synchronous flush.
module ab_pipe_flex #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 op,
  input  logic [W-1:0]               a,
  input  logic [W-1:0]               b,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [W-1:0]               q,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OW = $clog2(DEPTH+1);

  logic [W-1:0]     d_q [DEPTH];
  logic [W-1:0]     d_d [DEPTH];
  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [DEPTH-1:0] adv;
  logic [W-1:0]     f;
  logic             adv_acc;
  logic [OW-1:0]    occ_cnt;

  always_comb begin
    case (op)
      2'b00:   f = a & b;
      2'b01:   f = a | b;
      2'b10:   f = a ^ b;
      default: f = ~(a & b);
    endcase
  end

  // A stage may advance if downstream is taking data or any stage at or after it is empty.
  always_comb begin
    adv     = '0;
    adv_acc = out_ready;
    for (int k = DEPTH-1; k >= 0; k--) begin
      adv_acc = adv_acc | ~v_q[k];
      adv[k]  = adv_acc;
    end
  end

  assign in_ready  = adv[0] & ~flush;
  assign out_valid = v_q[DEPTH-1];
  assign q         = d_q[DEPTH-1];

  always_comb begin
    d_d = d_q;
    v_d = v_q;
    if (flush) begin
      v_d = '0;
    end else begin
      if (adv[0]) begin
        d_d[0] = f;
        v_d[0] = in_valid & in_ready;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (adv[k]) begin
          d_d[k] = d_q[k-1];
          v_d[k] = v_q[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        d_q[k] <= '0;
      end
      v_q <= '0;
    end else begin
      d_q <= d_d;
      v_q <= v_d;
    end
  end

  always_comb begin
    occ_cnt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ_cnt = occ_cnt + OW'(v_q[k]);
    end
  end

  assign occupancy = occ_cnt;

endmodule

// File: tb/tb_ab_pipe_flex.sv
// Directed bench for ab_pipe_flex: a DEPTH=2 and a DEPTH=3 instance share the stimulus.
module tb_ab_pipe_flex;

  logic       clk;
  logic       reset;
  logic [1:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       in_valid;
  logic       out_ready;
  logic       flush;

  logic       in_ready2, out_valid2, in_ready3, out_valid3;
  logic [7:0] q2, q3;
  logic [1:0] occ2, occ3;

  int n_tests = 0;
  int n_fail  = 0;
  int accepts;
  logic [7:0] exp_q [4];

  ab_pipe_flex #(.W(8), .DEPTH(2)) u_dut2 (
    .clk(clk), .reset(reset), .op(op), .a(a), .b(b),
    .in_valid(in_valid), .in_ready(in_ready2),
    .out_valid(out_valid2), .out_ready(out_ready),
    .q(q2), .flush(flush), .occupancy(occ2)
  );

  ab_pipe_flex #(.W(8), .DEPTH(3)) u_dut3 (
    .clk(clk), .reset(reset), .op(op), .a(a), .b(b),
    .in_valid(in_valid), .in_ready(in_ready3),
    .out_valid(out_valid3), .out_ready(out_ready),
    .q(q3), .flush(flush), .occupancy(occ3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; op = 2'b00; a = '0; b = '0;
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    #12;
    check("rst_out_valid2", out_valid2, 0);
    check("rst_q2",         q2,         0);
    check("rst_occ2",       occ2,       0);
    check("rst_in_ready3",  in_ready3,  1);
    check("rst_occ3",       occ3,       0);

    // Single AND transaction through DEPTH=2
    do_reset();
    op = 2'b00; a = 8'hF0; b = 8'h3C; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("t1_occ_after1",   occ2,       1);
    check("t1_valid_after1", out_valid2, 0);
    tick();
    check("t1_valid_after2", out_valid2, 1);
    check("t1_q",            q2,         8'h30);
    check("t1_occ_after2",   occ2,       1);
    tick();
    check("t1_valid_after3", out_valid2, 0);
    check("t1_occ_after3",   occ2,       0);

    // All four ops back to back, no gaps
    do_reset();
    exp_q[0] = 8'h0A; exp_q[1] = 8'hAF; exp_q[2] = 8'hA5; exp_q[3] = 8'hF5;
    a = 8'hAA; b = 8'h0F; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        in_valid = 1'b1;
        op = 2'(i);
      end else begin
        in_valid = 1'b0;
        op = 2'b00;
      end
      tick();
      if (i >= 1 && i <= 4) begin
        check($sformatf("t2_valid%0d", i-1), out_valid2, 1);
        check($sformatf("t2_q%0d", i-1),     q2,         exp_q[i-1]);
      end
    end
    check("t2_drained", out_valid2, 0);

    // DEPTH=3 fill under stall, then drain in order
    do_reset();
    op = 2'b01; b = 8'h00; in_valid = 1'b1; out_ready = 1'b0;
    accepts = 0;
    for (int i = 0; i < 6; i++) begin
      a = 8'h10 + 8'(accepts);
      if (in_ready3) accepts++;
      tick();
    end
    check("t3_accepts",  accepts,   3);
    check("t3_in_ready", in_ready3, 0);
    check("t3_occ",      occ3,      3);
    check("t3_q_stall",  q3,        8'h10);
    tick();
    check("t3_q_stable", q3,        8'h10);
    check("t3_valid",    out_valid3, 1);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t3_drain_q%0d", i), q3, 8'h10 + 8'(i));
      tick();
    end
    check("t3_drain_empty", out_valid3, 0);
    check("t3_drain_occ",   occ3,       0);

    // Bubble collapse behind a stalled last stage
    do_reset();
    op = 2'b01; b = 8'h00; a = 8'h55; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("t4_occ1",  occ3, 1);
    check("t4_q_old", q3,   8'h55);
    a = 8'h66; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("t4_occ2_a", occ3, 2);
    tick();
    check("t4_occ2_b",    occ3,      2);
    check("t4_q_stable",  q3,        8'h55);
    check("t4_in_ready",  in_ready3, 1);

    // Flush with two results in flight and an item offered
    do_reset();
    op = 2'b01; b = 8'h00; out_ready = 1'b0; in_valid = 1'b1;
    a = 8'h21;
    tick();
    a = 8'h22;
    tick();
    check("t5_occ_pre", occ2, 2);
    a = 8'h99; flush = 1'b1;
    #1;
    check("t5_in_ready_flush", in_ready2, 0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("t5_occ_post",   occ2,       0);
    check("t5_valid_post", out_valid2, 0);
    check("t5_q_kept",     q2,         8'h21);
    tick();
    check("t5_not_accepted", occ2, 0);

    // Asynchronous reset mid-stream, then resume
    do_reset();
    op = 2'b01; b = 8'h00; out_ready = 1'b1; in_valid = 1'b1;
    a = 8'h31;
    tick();
    a = 8'h32;
    tick();
    a = 8'h33;
    tick();
    check("t6_q_pre", q3, 8'h31);
    #3;
    reset = 1'b1;
    #1;
    check("t6_valid_rst",    out_valid3, 0);
    check("t6_q_rst",        q3,         0);
    check("t6_occ_rst",      occ3,       0);
    check("t6_in_ready_rst", in_ready3,  1);
    #2;
    reset = 1'b0; a = 8'h77; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("t6_occ_resume", occ3, 1);
    tick();
    tick();
    check("t6_valid_resume", out_valid3, 1);
    check("t6_q_resume",     q3,         8'h77);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
